// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder in front of an inferred word RAM.
// Optional macro DATA_MEM_BOUNDS_CHECK_EN enables out-of-range detection and a sticky bus_error.
module data_mem_responder #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             request,
    input  logic             wren,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] writedata,
    output logic             response,
    output logic [WIDTH-1:0] readdata,
    output logic             bus_error
);

    localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    localparam int CAP_W = WIDTH;
`else
    localparam int CAP_W = ADDR_BITS;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wren_q, wren_d;
    logic [CAP_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             response_q, response_d;
    logic             bus_error_q, bus_error_d;
    logic [WIDTH-1:0] readdata_q;

    logic [WIDTH-1:0] mem_array [DEPTH];

    logic                 access_fire;
    logic                 oob;
    logic                 mem_we;
    logic                 mem_re;
    logic [ADDR_BITS-1:0] mem_idx;

    assign mem_idx     = addr_q[ADDR_BITS-1:0];
    assign access_fire = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    assign oob = |addr_q[WIDTH-1:ADDR_BITS];
`else
    // Upper address bits alias onto the decoded range and are dropped at capture.
    logic unused_upper_addr;
    assign unused_upper_addr = ^address[WIDTH-1:ADDR_BITS];
    assign oob = 1'b0;
`endif

    // Reset on the access edge must leave the array untouched.
    assign mem_we = access_fire && wren_q && !oob && !reset;
    assign mem_re = access_fire && !wren_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wren_d      = wren_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        response_d  = 1'b0;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    wren_d  = wren;
                    addr_d  = address[CAP_W-1:0];
                    wdata_d = writedata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    response_d = 1'b1;
                    state_d    = DONE;
                    if (oob) begin
                        bus_error_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            response_q  <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            response_q  <= response_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[mem_idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (mem_re) begin
            readdata_q <= oob ? '0 : mem_array[mem_idx];
        end
    end

    assign response  = response_q;
    assign readdata  = readdata_q;
    assign bus_error = bus_error_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data bus. It accepts single-word load/store requests from the core's `request`/`wren`/`address`/`writedata` outputs and answers with a one-cycle `response` pulse and `readdata`, after a configurable fixed latency. It sits between the core and on-chip data RAM. It replaces the hand-driven `response`/`readdata` stimulus used in core-level benches.

## Interface

Parameters:
- `WIDTH`, 32, data and address bus width.
- `ADDR_BITS`, 10, number of word-address bits actually decoded; memory depth is 2^ADDR_BITS words.
- `LATENCY`, 3, cycles from request capture to response pulse; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `request`  in  1  core access request; level, held by core until it sees `response`.
- `wren`  in  1  1 = store, 0 = load; sampled with `request`.
- `address`  in  WIDTH  word address; sampled with `request`.
- `writedata`  in  WIDTH  store data; sampled with `request`.
- `response`  out  1  one-cycle completion pulse.
- `readdata`  out  WIDTH  load result; valid while `response`=1 for a load.
- `bus_error`  out  1  sticky out-of-range flag (see Configuration).

## Operation

- Internal array: 2^ADDR_BITS words × WIDTH bits. Contents are not cleared by reset.
- FSM states:
  - IDLE: if `request`=1, capture `wren`, `address`, `writedata`, load counter with LATENCY-1, and go to WAIT.
  - WAIT: if counter≠0, decrement it. If counter=0, perform the access and go to DONE. For a store, write the captured data. For a load, register the array word into `readdata`. In both cases set `response`=1 for exactly one cycle.
  - DONE: `response`=0. Stay here while `request`=1; go to IDLE when `request`=0. This prevents a held request from being serviced twice.
- Inputs are ignored outside the IDLE capture cycle. Changes during WAIT/DONE have no effect.
- Index: captured `address[ADDR_BITS-1:0]`.
- On a store, `readdata` holds its previous value.
- Reset values: `response`=0, `readdata`=0, `bus_error`=0, state IDLE, counter 0.
- Reset during WAIT aborts the access. A pending store is discarded, no response is issued, and the array is unchanged.
- Reset asserted in the same cycle as `request` wins; nothing is captured.

## Timing

- `request` sampled high at edge k (state IDLE) → `response` high during the cycle after edge k+LATENCY. The store commits at that same edge.
- With LATENCY=1: capture at edge k, response after edge k+1.
- `response` is high for exactly 1 cycle per accepted request.
- Request dropped at the edge after the response → IDLE after that edge. The next request can be captured at the following edge.
- Minimum request-to-request spacing is LATENCY+2 cycles.
- A load immediately following a store to the same address returns the new data.

## Configuration

- `DATA_MEM_BOUNDS_CHECK_EN` defined:
  - An access is out of range when captured `address[WIDTH-1:ADDR_BITS]` is nonzero.
  - Out-of-range stores are dropped, and out-of-range loads return 0.
  - The access still completes with normal `response` timing.
  - `bus_error` is set at the response edge and cleared only by `reset`.
- Undefined: upper address bits are ignored and addresses alias modulo 2^ADDR_BITS. `bus_error` is tied 0.

## Test plan

- Store/load: LATENCY=3. Store 7 to address 2, then load address 2 → `response` 3 cycles after each capture, and the load returns `readdata`=7.
- Held request: core keeps `request`=1 for 6 cycles after the response → exactly one `response` pulse and no second write. A new request after the drop is serviced normally.
- Back-to-back ordering: store 13 to address 1, load address 1 at the earliest legal cycle → returns 13. The store leaves the previous `readdata` unchanged.
- Reset mid-WAIT: store 0xFF to address 5 (prior value 0x11), assert reset 1 cycle after capture → no response, and a subsequent load of address 5 returns 0x11.
- LATENCY=1: load address 0 → `response` 1 cycle after capture.
- Bounds: with `DATA_MEM_BOUNDS_CHECK_EN`, load 0x00000400 (ADDR_BITS=10) → `readdata`=0, `bus_error`=1 stays set. Without the macro, the same load returns the contents of address 0 and `bus_error`=0.
